ped_crossing_ctrl: RTL and testbench
====================================

Name: ped_crossing_ctrl

Overview:
- Pedestrian crossing stage directly downstream of the traffic-light controller. Consumes its one-hot red/yellow/green outputs and a raw pedestrian push-button.
- Grants a timed WALK interval only at the start of a red phase, then a flashing-DON'T-WALK clearance with countdown.
- Drives the pedestrian signal head and the "request accepted" lamp.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a button level change is accepted.
- WALK_CYCLES, 5: length of the WALK state in clk cycles.
- CLEAR_CYCLES, 4: length of the flashing clearance state in clk cycles (maximum 15, so it fits in countdown).
- FLASH_HALF, 1: clk cycles per half-period of the flashing dont_walk during clearance.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- red  input  1  vehicle red lamp from the traffic-light controller.
- yellow  input  1  vehicle yellow lamp from the traffic-light controller.
- green  input  1  vehicle green lamp from the traffic-light controller.
- ped_button  input  1  raw, asynchronous, bouncy push-button (1 = pressed).
- walk  output  1  WALK lamp.
- dont_walk  output  1  DON'T-WALK lamp (steady or flashing).
- req_pending  output  1  request-accepted lamp.
- countdown  output  4  remaining clearance cycles; 0 outside CLEAR.
- fault  output  1  vehicle-light inputs not one-hot.

Behaviour:
- Reset (async, active-high):
  - State = IDLE; req_pending=0, walk=0, dont_walk=1, countdown=0, fault=0.
  - Synchronizer, debounce counter, red_q and all timers = 0.
- Button path:
  - Two-flop synchronizer on ped_button.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - A 0->1 edge of the debounced level is a press.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
- Request latch:
  - A press sets req_pending on the next edge.
  - Further presses while pending have no effect.
  - req_pending clears on the edge that enters WALK.
  - If a press and WALK entry occur on the same edge, the press is consumed (req_pending stays 0).
  - Presses during WALK/CLEAR set req_pending, which is served at the next red phase.
- Red-start detect: red_q is red registered; red_rise = red & ~red_q.
- States (Moore; outputs decoded from state/timers):
  - IDLE: walk=0, dont_walk=1. If req_pending & red_rise, go to WALK next edge with timer=WALK_CYCLES-1.
    - A request arriving mid-red waits for the next red_rise.
  - WALK: walk=1, dont_walk=0. Stays exactly WALK_CYCLES cycles, then CLEAR with timer=CLEAR_CYCLES-1.
  - CLEAR: walk=0.
    - dont_walk=1 on the first cycle, toggling every FLASH_HALF cycles.
    - countdown = CLEAR_CYCLES on the first cycle, decrementing to 1 on the last.
    - Stays exactly CLEAR_CYCLES cycles, then IDLE.
  - FAULT: walk=0, dont_walk=1 steady, countdown=0, fault=1.
- Safety abort: red==0 in WALK or CLEAR forces IDLE on the next edge. Timers clear; req_pending is unaffected.
- Fault:
  - {red,yellow,green} not exactly one-hot in any state forces FAULT on the next edge and clears req_pending.
  - Presses are ignored while in FAULT.
  - FAULT exits to IDLE on the first edge with one-hot inputs.
  - Fault takes priority over abort and over normal transitions.
- Timing with defaults (red held 10 cycles): red_rise on red cycle 1, WALK on red cycles 2-6, CLEAR on cycles 7-10, IDLE when red drops.
- Timer widths are $clog2-sized from the parameters. No wrap-around is possible: each timer is reloaded at every state entry.

Decomposition:
- Package ped_pkg holds:
  - state enum {IDLE, WALK, CLEAR, FAULT} as 2-bit localparams;
  - default timing constants;
  - COUNT_W = 4.
- Sub-module ped_debounce (synchronizer + stability counter + rising-edge press pulse), parameterised by DEBOUNCE_CYCLES.
- The FSM, request latch and output decode live in ped_crossing_ctrl.

Test Plan:
- Reset mid-CLEAR (reset high 2 cycles) -> walk=0, dont_walk=1, countdown=0, req_pending=0 immediately (async), state IDLE after release.
- Clean press during green (ped_button high 8 cycles) -> req_pending=1 six cycles after the button rises (2 sync + 4 debounce); on the next red: WALK for 5 cycles starting 1 cycle after red rises, then CLEAR with countdown 4,3,2,1 and dont_walk 1,0,1,0, then IDLE; req_pending clears on WALK entry.
- Bouncy button (high 2, low 1, high 3 cycles) -> req_pending stays 0; a WALK never starts.
- Press debounced mid-red (red cycle 4) -> no WALK in that red phase; WALK starts 1 cycle after the following red rise.
- Red forced low on the third WALK cycle -> IDLE next edge, walk=0, dont_walk=1, countdown=0.
- Inputs red=1 and green=1 together for 1 cycle during WALK -> FAULT next edge (fault=1, walk=0, req_pending=0); returns to IDLE on the first one-hot cycle.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared types and default timing for the pedestrian crossing controller.
// The state encoding is fixed so that the debug state output reads the same everywhere.
package ped_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_FAULT = 2'd3
  } ped_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_WALK_CYCLES     = 5;
  localparam int DEF_CLEAR_CYCLES    = 4;
  localparam int DEF_FLASH_HALF      = 1;
  localparam int COUNT_W             = 4;

  function automatic logic one_hot3(input logic a, input logic b, input logic c);
    return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
  endfunction

endpackage

// File: rtl/ped_debounce.sv
// Two-flop synchronizer and stability counter for the raw push-button.
// press pulses for one cycle, aligned with the edge on which the debounced level rises.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_button,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // cnt counts consecutive samples that disagree with the accepted level
  assign accept = (sync2 != level) && (cnt == CNT_LAST);
  assign press  = accept && sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= ped_button;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing stage: grants WALK at the start of a red phase when a request is
// pending, then a flashing clearance with countdown; drops to FAULT on non one-hot lamps.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
  parameter int CLEAR_CYCLES    = DEF_CLEAR_CYCLES,
  parameter int FLASH_HALF      = DEF_FLASH_HALF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               red,
  input  logic               yellow,
  input  logic               green,
  input  logic               ped_button,
  output logic               walk,
  output logic               dont_walk,
  output logic               req_pending,
  output logic [COUNT_W-1:0] countdown,
  output logic               fault,
  output logic [1:0]         state
);

  localparam int T_MAX   = (WALK_CYCLES > CLEAR_CYCLES) ? WALK_CYCLES : CLEAR_CYCLES;
  localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int FL_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [TIMER_W-1:0] WALK_LAST  = TIMER_W'(WALK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [FL_W-1:0]    FLASH_LAST = FL_W'(FLASH_HALF - 1);

  ped_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FL_W-1:0]    flash_cnt_q, flash_cnt_d;
  logic               flash_on_q, flash_on_d;
  logic               req_q, req_d;
  logic               red_q;
  logic               red_rise;
  logic               lamps_ok;
  logic               press;

  ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .ped_button (ped_button),
    .press      (press)
  );

  assign red_rise = red & ~red_q;
  assign lamps_ok = one_hot3(red, yellow, green);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b0;
      req_q       <= 1'b0;
      red_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      req_q       <= req_d;
      red_q       <= red;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    req_d       = req_q;
    if (!lamps_ok) begin
      state_d     = ST_FAULT;
      timer_d     = '0;
      flash_cnt_d = '0;
      req_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // a press on the WALK-entry edge is absorbed by that WALK
          if (req_q && red_rise) begin
            state_d = ST_WALK;
            timer_d = WALK_LAST;
            req_d   = 1'b0;
          end else if (press) begin
            req_d = 1'b1;
          end
        end
        ST_WALK: begin
          if (press) req_d = 1'b1;
          if (!red) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == '0) begin
            state_d     = ST_CLEAR;
            timer_d     = CLEAR_LAST;
            flash_cnt_d = '0;
            flash_on_d  = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_CLEAR: begin
          if (press) req_d = 1'b1;
          if (!red || timer_q == '0) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 1'b1;
            if (flash_cnt_q == FLASH_LAST) begin
              flash_cnt_d = '0;
              flash_on_d  = ~flash_on_q;
            end else begin
              flash_cnt_d = flash_cnt_q + 1'b1;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    countdown = '0;
    fault     = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      ST_CLEAR: begin
        dont_walk = flash_on_q;
        countdown = COUNT_W'(timer_q) + COUNT_W'(1);
      end
      ST_FAULT: fault = 1'b1;
    endcase
  end

  assign req_pending = req_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Randomized and directed stimulus against a cycle-level behavioural model of the crossing;
// expected outputs are queued per cycle and compared by an independent monitor.
module tb_ped_crossing_ctrl;
  import ped_pkg::*;

  localparam int DB = 4;
  localparam int WC = 5;
  localparam int CC = 4;
  localparam int FH = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       red = 1'b1, yellow = 1'b0, green = 1'b0, ped_button = 1'b0;
  logic       walk, dont_walk, req_pending, fault;
  logic [3:0] countdown;
  logic [1:0] state;

  always #5 clk = ~clk;

  ped_crossing_ctrl #(
    .DEBOUNCE_CYCLES(DB), .WALK_CYCLES(WC), .CLEAR_CYCLES(CC), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .ped_button(ped_button), .walk(walk), .dont_walk(dont_walk),
    .req_pending(req_pending), .countdown(countdown), .fault(fault), .state(state)
  );

  // {state, walk, dont_walk, req_pending, countdown, fault}
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cycle = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got st=%0d w=%b dw=%b req=%b cd=%0d f=%b, want st=%0d w=%b dw=%b req=%b cd=%0d f=%b",
                  name, cycle, act[9:8], act[7], act[6], act[5], act[4:1], act[0],
                  exp[9:8], exp[7], exp[6], exp[5], exp[4:1], exp[0]);
  endtask

  function automatic logic [9:0] dut_out();
    return {state, walk, dont_walk, req_pending, countdown, fault};
  endfunction

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 walk, 2 clear, 3 fault; m_k: cycles already spent in that mode
  int m_mode, m_k;
  bit m_req, m_red_prev, m_level;
  bit raw_hist[$];
  bit s_hist[$];

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_req = 0; m_red_prev = 0; m_level = 0;
    raw_hist = {};
    raw_hist.push_back(1'b0);
    raw_hist.push_back(1'b0);
    s_hist = {};
    for (int i = 0; i < DB; i++) s_hist.push_back(1'b0);
  endtask

  function automatic logic [9:0] model_out();
    logic       w, dw, f;
    logic [3:0] cd;
    w  = (m_mode == 1);
    dw = (m_mode == 2) ? (((m_k / FH) % 2) == 0) : (m_mode != 1);
    cd = (m_mode == 2) ? 4'(CC - m_k) : 4'd0;
    f  = (m_mode == 3);
    return {2'(m_mode), w, dw, m_req, cd, f};
  endfunction

  task automatic model_edge(input bit r, input bit y, input bit g, input bit b);
    bit s, all_diff, press, red_rise;
    int hot;
    // the debouncer sees the button as it was two edges earlier
    s = raw_hist.pop_front();
    raw_hist.push_back(b);
    s_hist.push_back(s);
    if (s_hist.size() > DB) void'(s_hist.pop_front());
    all_diff = 1;
    foreach (s_hist[i]) if (s_hist[i] == m_level) all_diff = 0;
    press = 0;
    if (all_diff) begin
      m_level = s;
      press = s;
    end
    hot = int'(r) + int'(y) + int'(g);
    red_rise = r && !m_red_prev;
    if (hot != 1) begin
      m_mode = 3; m_k = 0; m_req = 0;
    end else begin
      case (m_mode)
        0: if (m_req && red_rise) begin m_mode = 1; m_k = 0; m_req = 0; end
           else if (press) m_req = 1;
        1: begin
          if (press) m_req = 1;
          if (!r) begin m_mode = 0; m_k = 0; end
          else if (m_k == WC - 1) begin m_mode = 2; m_k = 0; end
          else m_k++;
        end
        2: begin
          if (press) m_req = 1;
          if (!r || m_k == CC - 1) begin m_mode = 0; m_k = 0; end
          else m_k++;
        end
        default: begin m_mode = 0; m_k = 0; end
      endcase
    end
    m_red_prev = r;
  endtask

  // ---------------- driver ----------------
  bit btn_plan[$];
  bit last_rst = 0;

  task automatic step(input bit r, input bit y, input bit g, input bit b, input bit rst);
    @(posedge clk);
    #1;
    cycle++;
    red = r; yellow = y; green = g; ped_button = b;
    reset = rst;
    if (rst) model_reset();
    if (rst && !last_rst) begin
      #1;
      check("async_reset", dut_out(), {2'(ST_IDLE), 1'b0, 1'b1, 1'b0, 4'd0, 1'b0});
    end
    exp_q.push_back(model_out());
    if (!rst) model_edge(r, y, g, b);
    last_rst = rst;
  endtask

  task automatic plan(input int zeros, input int ones);
    repeat (zeros) btn_plan.push_back(1'b0);
    repeat (ones) btn_plan.push_back(1'b1);
  endtask

  task automatic lights(input bit r, input bit y, input bit g, input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = 1'b0;
      if (btn_plan.size() > 0) b = btn_plan.pop_front();
      step(r, y, g, b, 1'b0);
    end
  endtask

  task automatic bad_lamps();
    logic [2:0] v;
    v = 3'b000;
    case ($urandom_range(0, 4))
      0: v = 3'b000;
      1: v = 3'b110;
      2: v = 3'b101;
      3: v = 3'b011;
      default: v = 3'b111;
    endcase
    step(v[2], v[1], v[0], 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_out(), e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    lights(1, 0, 0, 3);

    // clean press during green, served on the next red
    lights(0, 0, 1, 4);
    plan(0, 8);
    lights(0, 0, 1, 12);
    lights(0, 1, 0, 2);
    lights(1, 0, 0, 10);
    lights(0, 0, 1, 3);

    // bouncy button is ignored
    plan(0, 2); plan(1, 3);
    lights(0, 0, 1, 10);
    lights(0, 1, 0, 2);
    lights(1, 0, 0, 10);

    // request accepted on red cycle 4 waits for the following red
    plan(3, 8);
    lights(0, 0, 1, 5);
    lights(1, 0, 0, 10);
    lights(0, 0, 1, 4);
    lights(0, 1, 0, 2);
    lights(1, 0, 0, 10);

    // red drops on the third WALK cycle
    plan(0, 8);
    lights(0, 0, 1, 10);
    lights(0, 1, 0, 1);
    lights(1, 0, 0, 3);
    lights(0, 0, 1, 5);

    // red and green together during WALK
    plan(0, 8);
    lights(0, 0, 1, 10);
    lights(0, 1, 0, 1);
    lights(1, 0, 0, 4);
    step(1, 0, 1, 0, 0);
    lights(1, 0, 0, 5);
    lights(0, 0, 1, 3);

    // reset in the middle of CLEAR
    plan(0, 8);
    lights(0, 0, 1, 12);
    lights(0, 1, 0, 2);
    lights(1, 0, 0, 8);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    lights(1, 0, 0, 3);
    lights(0, 0, 1, 4);

    // random traffic phases with random button activity and lamp faults
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 3))
        0: ;
        1: plan($urandom_range(0, 6), $urandom_range(5, 10));
        2: begin
          plan($urandom_range(0, 4), $urandom_range(1, 3));
          plan($urandom_range(1, 2), $urandom_range(1, 3));
        end
        default: begin
          plan($urandom_range(0, 3), $urandom_range(4, 8));
          plan($urandom_range(1, 5), $urandom_range(1, 9));
        end
      endcase
      if ($urandom_range(0, 9) == 0) begin
        step(0, 0, 1, 0, 1);
        if ($urandom_range(0, 1) == 1) step(0, 0, 1, 0, 1);
      end
      lights(0, 0, 1, $urandom_range(3, 12));
      lights(0, 1, 0, $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin
        lights(1, 0, 0, $urandom_range(1, 8));
        bad_lamps();
      end
      lights(1, 0, 0, $urandom_range(3, 14));
    end
    lights(0, 0, 1, 3);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
